io_uart_tx: RTL and testbench

Memory-mapped UART transmit peripheral that sits on the core's I/O write bus (`io_write_addr`/`io_write_en`/`io_write_data`) and acts as the responder for the core's stores.
- Decodes writes to its address window and buffers transmit bytes in a FIFO.
- Serializes each byte as an 8N1 frame on `uart_tx`.
- Returns status through a registered read port.

---
 rtl/io_uart_tx.sv | 278 +++++++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx
//
// Memory-mapped UART transmitter. Stores to TXDATA are queued in a
// circular FIFO, and each byte goes out on uart_tx as an asynchronous serial
// frame. The default frame is 8N1: a start bit, 8 data bits sent LSB first,
// and a stop bit. Status is returned through a registered read port.
//
// Register window (BASE_ADDR must be word aligned):
//   BASE+0  TXDATA  write only: bits [7:0] are pushed into the FIFO. A write
//                   while the FIFO is full is dropped and sets the sticky
//                   overflow flag. Reads return 0.
//   BASE+4  STATUS  {28'b0, overflow, busy, empty, full}. Writing 1 to bit 3
//                   clears overflow.
//   Any other address: writes are ignored and reads return 0.
//
// Optional feature: when `IO_UART_TX_PARITY_EN is defined, an even parity bit
// is sent between the data bits and the stop bit, making an 11-bit frame.
//
// Parameters:
//   BASE_ADDR    base of the 8-byte register window
//   CLKS_PER_BIT clock cycles per serial bit (>= 2)
//   FIFO_DEPTH   transmit FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   io_write_*     core store bus (address, one-cycle strobe, data)
//   io_read_en     read strobe; io_read_data is updated on that edge
//   io_read_addr   read address
//   io_read_data   registered read result, held until the next read
//   uart_tx        serial output, idle high, driven from a flop
//   tx_busy        high while a frame is active or the FIFO holds data
module io_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_write_addr,
  input  logic        io_write_en,
  input  logic [31:0] io_write_data,
  input  logic        io_read_en,
  input  logic [31:0] io_read_addr,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] wr_offset;
  logic [31:0] rd_offset;
  logic        wr_in_window;
  logic        rd_in_window;
  logic        wr_txdata;
  logic        wr_status;
  logic        rd_status;

  assign wr_offset    = io_write_addr - BASE_ADDR;
  assign rd_offset    = io_read_addr - BASE_ADDR;
  assign wr_in_window = (wr_offset[31:3] == '0);
  assign rd_in_window = (rd_offset[31:3] == '0);
  assign wr_txdata    = io_write_en && wr_in_window && !wr_offset[2];
  assign wr_status    = io_write_en && wr_in_window && wr_offset[2];
  assign rd_status    = rd_in_window && rd_offset[2];

  // Bits that carry no meaning for this peripheral.
  logic unused_bits;
  assign unused_bits = ^{io_write_data[31:8], wr_offset[1:0], rd_offset[1:0]};

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still accepted in that case.
  assign push_ok   = wr_txdata && (!fifo_full || pop);
  assign push_drop = wr_txdata && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= io_write_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_e         state;
  tx_state_e         next_state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] next_baud;
  logic [2:0]        bit_idx;
  logic [2:0]        next_bit_idx;
  logic [7:0]        shift_reg;
  logic [7:0]        next_shift;
  logic              tx_q;
  logic              next_tx;
  logic              baud_done;

  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= BAUD_RELOAD;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= next_state;
      baud_cnt  <= next_baud;
      bit_idx   <= next_bit_idx;
      shift_reg <= next_shift;
      tx_q      <= next_tx;
    end
  end

  // The line value for the upcoming bit is computed here and registered, so
  // uart_tx changes on the same edge as the state/bit it belongs to.
  always_comb begin
    next_state   = state;
    next_baud    = baud_cnt - 1'b1;
    next_bit_idx = bit_idx;
    next_shift   = shift_reg;
    next_tx      = tx_q;
    pop          = 1'b0;

    unique case (state)
      S_IDLE: begin
        next_baud = BAUD_RELOAD;
        next_tx   = 1'b1;
        if (!fifo_empty) begin
          next_state = S_START;
          pop        = 1'b1;
          next_shift = fifo_mem[rd_ptr];
          next_tx    = 1'b0;
        end
      end

      S_START: begin
        if (baud_done) begin
          next_state   = S_DATA;
          next_baud    = BAUD_RELOAD;
          next_bit_idx = '0;
          next_tx      = shift_reg[0];
        end
      end

      S_DATA: begin
        if (baud_done) begin
          next_baud = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            next_state = S_PARITY;
            next_tx    = ^shift_reg;
`else
            next_state = S_STOP;
            next_tx    = 1'b1;
`endif
          end else begin
            next_bit_idx = bit_idx + 1'b1;
            next_tx      = shift_reg[next_bit_idx];
          end
        end
      end

`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          next_state = S_STOP;
          next_baud  = BAUD_RELOAD;
          next_tx    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (baud_done) begin
          next_baud = BAUD_RELOAD;
          // Chain straight into the next start bit so queued bytes leave
          // without an idle gap.
          if (!fifo_empty) begin
            next_state = S_START;
            pop        = 1'b1;
            next_shift = fifo_mem[rd_ptr];
            next_tx    = 1'b0;
          end else begin
            next_state = S_IDLE;
            next_tx    = 1'b1;
          end
        end
      end

      default: begin
        next_state = S_IDLE;
        next_baud  = BAUD_RELOAD;
        next_tx    = 1'b1;
      end
    endcase
  end

  assign uart_tx = tx_q;
  assign tx_busy = (state != S_IDLE) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Status, overflow flag and read port
  // ---------------------------------------------------------------------------
  logic        overflow;
  logic [31:0] status_word;

  assign status_word = {28'b0, overflow, tx_busy, fifo_empty, fifo_full};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (wr_status && io_write_data[3]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_read_data <= '0;
    end else if (io_read_en) begin
      io_read_data <= rd_status ? status_word : '0;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
`timescale 1ns/1ps
module tb_io_uart_tx;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
`ifdef IO_UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif
  localparam int          FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_write_addr;
  logic        io_write_en;
  logic [31:0] io_write_data;
  logic        io_read_en;
  logic [31:0] io_read_addr;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        tx_busy;

  io_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_write_addr(io_write_addr),
    .io_write_en  (io_write_en),
    .io_write_data(io_write_data),
    .io_read_en   (io_read_en),
    .io_read_addr (io_read_addr),
    .io_read_data (io_read_data),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc          = 0;
  int unsigned frames_seen  = 0;
  logic [7:0]  sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame monitor: decodes uart_tx at the falling edge and checks every bit
  // is held for CPB cycles; decoded bytes are compared against the queue.
  int                    mon_pos = -1;
  logic [FRAME_BITS-1:0] mon_bits;
  logic                  mon_cur;

  task automatic frame_done();
    logic [7:0] d;
    d = mon_bits[8:1];
    frames_seen++;
    check("stop_bit", 32'(mon_bits[FRAME_BITS-1]), 32'd1);
`ifdef IO_UART_TX_PARITY_EN
    check("parity_bit", 32'(mon_bits[9]), 32'(^d));
`endif
    check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) check("frame_data", 32'(d), 32'(sb_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (uart_tx == 1'b0) begin
        mon_pos  = 0;
        mon_cur  = 1'b0;
        mon_bits = '0;
      end
    end else begin
      mon_pos++;
      if (mon_pos % CPB == 0) begin
        mon_cur = uart_tx;
        mon_bits[mon_pos / CPB] = uart_tx;
      end else begin
        check("bit_hold", 32'(uart_tx), 32'(mon_cur));
      end
      if (mon_pos == FRAME_CYC - 1) begin
        frame_done();
        mon_pos = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [31:0] addr, input logic [31:0] data);
    io_write_addr = addr;
    io_write_data = data;
    io_write_en   = 1'b1;
    @(posedge clk);
    #1;
    io_write_en   = 1'b0;
  endtask

  task automatic io_rd_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    io_read_addr = addr;
    io_read_en   = 1'b1;
    @(posedge clk);
    #1;
    io_read_en   = 1'b0;
    check(tag, io_read_data, exp);
  endtask

  // Waits for tx_busy to drop; dur is the busy time measured from the edge
  // after the write captured in t0.
  task automatic wait_idle(input int unsigned t0, input int budget, output int unsigned dur);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_budget", 32'(tx_busy), 32'd0);
    dur = cyc - t0 - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned dur;
    int unsigned frames_before;

    rst           = 1'b1;
    io_write_addr = '0;
    io_write_en   = 1'b0;
    io_write_data = '0;
    io_read_en    = 1'b0;
    io_read_addr  = '0;
    tick(3);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_read_data", io_read_data, 32'h0);
    rst = 1'b0;
    tick(2);
    io_rd_check(BASE + 32'd4, 32'h2, "status_reset");

    // Single frame A5: first start-bit edge and total busy time.
    sb_q.push_back(8'hA5);
    io_wr(BASE, 32'h0000_00A5);
    t0 = cyc;
    @(negedge clk);
    check("busy_after_write", 32'(tx_busy), 32'd1);
    check("tx_before_pop", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("tx_start_edge", 32'(uart_tx), 32'd0);
    wait_idle(t0, 200, dur);
    check("single_frame_len", dur, 32'(FRAME_CYC));

    // Three consecutive writes: contiguous frames.
    frames_before = frames_seen;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h02);
    sb_q.push_back(8'h03);
    io_wr(BASE, 32'h01);
    t0 = cyc;
    io_wr(BASE, 32'h02);
    io_wr(BASE, 32'h03);
    wait_idle(t0, 500, dur);
    check("three_frame_len", dur, 32'(3 * FRAME_CYC));
    check("three_frame_count", frames_seen - frames_before, 32'd3);
    io_rd_check(BASE + 32'd4, 32'h2, "status_after_three");

    // Overflow: one frame in flight, four buffered, sixth write dropped.
    frames_before = frames_seen;
    for (int unsigned i = 0; i < 5; i++) sb_q.push_back(8'(8'h10 + i));
    io_wr(BASE, 32'h10);
    tick(2);
    for (int unsigned i = 1; i < 6; i++) io_wr(BASE, 32'h10 + i);
    io_rd_check(BASE + 32'd4, 32'hD, "status_overflow_full");
    wait_idle(cyc, 400, dur);
    check("overflow_frame_count", frames_seen - frames_before, 32'd5);
    io_rd_check(BASE + 32'd4, 32'hA, "status_overflow_drained");
    io_wr(BASE + 32'd4, 32'h8);
    check("read_hold", io_read_data, 32'hA);
    io_rd_check(BASE + 32'd4, 32'h2, "status_after_clear");

    // Push into a full FIFO on the exact edge the FSM pops: accepted.
    frames_before = frames_seen;
    for (int unsigned i = 0; i < 6; i++) sb_q.push_back(8'(8'h20 + i));
    io_wr(BASE, 32'h20);
    tick(1);
    for (int unsigned i = 1; i < 5; i++) io_wr(BASE, 32'h20 + i);
    tick(FRAME_CYC - 5);
    io_wr(BASE, 32'h25);
    io_rd_check(BASE + 32'd4, 32'h5, "status_push_pop_full");
    wait_idle(cyc, 600, dur);
    check("push_pop_frame_count", frames_seen - frames_before, 32'd6);
    io_rd_check(BASE + 32'd4, 32'h2, "status_no_overflow");

    // Reads and writes outside the register window.
    io_rd_check(BASE + 32'd8, 32'h0, "rd_outside");
    io_rd_check(BASE + 32'd4, 32'h2, "rd_status_again");
    io_rd_check(BASE, 32'h0, "rd_txdata");
    io_wr(BASE + 32'd12, 32'h77);
    tick(2);
    check("outside_write_busy", 32'(tx_busy), 32'd0);
    io_rd_check(BASE + 32'd4, 32'h2, "status_outside_write");

    // Upper data bits are ignored; parity-bearing byte 07.
    sb_q.push_back(8'h3C);
    io_wr(BASE, 32'hDEAD_BE3C);
    wait_idle(cyc, 200, dur);
    sb_q.push_back(8'h07);
    io_wr(BASE, 32'h07);
    t0 = cyc;
    wait_idle(t0, 200, dur);
    check("frame07_len", dur, 32'(FRAME_CYC));

    // Reset in the middle of the data bits.
    sb_q.push_back(8'h00);
    io_wr(BASE, 32'h00);
    tick(8);
    check("tx_low_pre_reset", 32'(uart_tx), 32'd0);
    frames_before = frames_seen;
    rst = 1'b1;
    #1;
    check("tx_async_reset", 32'(uart_tx), 32'd1);
    check("busy_async_reset", 32'(tx_busy), 32'd0);
    sb_q.delete();
    tick(2);
    rst = 1'b0;
    io_rd_check(BASE + 32'd4, 32'h2, "status_after_reset");
    tick(60);
    check("no_frame_after_reset", frames_seen - frames_before, 32'd0);
    check("tx_idle_after_reset", 32'(uart_tx), 32'd1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
